// File: rtl/char_mem_arbiter.sv
// rtl/char_mem_arbiter.sv - single-port char RAM arbiter: display reads always win, host writes drain from a FIFO
// Optional activity counters (o_wr_count/o_stall_count) are built when ARB_STATS_EN is defined.
module char_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BLANK_ONLY = 1
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_blank,
    input  logic                            i_disp_req,
    input  logic [ADDR_W-1:0]               i_disp_addr,
    output logic [DATA_W-1:0]               o_disp_data,
    output logic                            o_disp_valid,
    input  logic                            i_host_valid,
    output logic                            o_host_ready,
    input  logic [ADDR_W-1:0]               i_host_addr,
    input  logic [DATA_W-1:0]               i_host_data,
    output logic                            o_mem_en,
    output logic                            o_mem_we,
    output logic [ADDR_W-1:0]               o_mem_addr,
    output logic [DATA_W-1:0]               o_mem_wdata,
    input  logic [DATA_W-1:0]               i_mem_rdata,
`ifdef ARB_STATS_EN
    output logic [15:0]                     o_wr_count,
    output logic [15:0]                     o_stall_count,
`endif
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]    r_level;
    logic                r_rd_pipe;
    logic                w_push, w_pop, w_drain_ok;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    // Registered level gates both ready and drain, so a fresh push is never popped in its own cycle
    // and a pop from a full FIFO cannot make room for a same-cycle push.
    assign o_host_ready = (r_level < LVL_W'(FIFO_DEPTH));
    assign w_push       = i_host_valid & o_host_ready;
    assign w_drain_ok   = (r_level != '0) && (i_blank || (BLANK_ONLY == 0));
    assign o_fifo_level = r_level;

    always_comb begin
        w_state_next = S_IDLE;
        w_pop        = 1'b0;
        w_mem_addr   = o_mem_addr;
        w_mem_wdata  = o_mem_wdata;
        if (i_disp_req) begin
            w_state_next = S_RD;
            w_mem_addr   = i_disp_addr;
        end else if (w_drain_ok) begin
            w_state_next = S_WR;
            w_pop        = 1'b1;
            w_mem_addr   = r_fifo_addr[r_rd_ptr];
            w_mem_wdata  = r_fifo_data[r_rd_ptr];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_next;
            o_mem_en    <= (w_state_next != S_IDLE);
            o_mem_we    <= (w_state_next == S_WR);
            o_mem_addr  <= w_mem_addr;
            o_mem_wdata <= w_mem_wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= i_host_addr;
            r_fifo_data[r_wr_ptr] <= i_host_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // RD cycle -> RAM data valid next cycle -> captured and presented the cycle after.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_pipe    <= 1'b0;
            o_disp_valid <= 1'b0;
            o_disp_data  <= '0;
        end else begin
            r_rd_pipe    <= (r_state == S_RD);
            o_disp_valid <= r_rd_pipe;
            if (r_rd_pipe) o_disp_data <= i_mem_rdata;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_wr_count, r_stall_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if ((r_state == S_WR) && (r_wr_count != 16'hFFFF))
                r_wr_count <= r_wr_count + 16'd1;
            if ((r_level != '0) && !w_pop && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign o_wr_count    = r_wr_count;
    assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_char_mem_arbiter.sv
// tb/tb_char_mem_arbiter.sv - self-checking bench: vector table, directed corner cases, random traffic vs queue model
module tb_char_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst, blank, dreq, hv;
    logic [AW-1:0] daddr, haddr;
    logic [DW-1:0] hdata;
    logic [DW-1:0] disp_data;
    logic          disp_valid, host_ready;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [2:0]    fifo_level;
`ifdef ARB_STATS_EN
    logic [15:0]   wr_count, stall_count;
`endif

    char_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D), .BLANK_ONLY(1)) dut (
        .i_clock(clk), .i_reset(rst), .i_blank(blank),
        .i_disp_req(dreq), .i_disp_addr(daddr), .o_disp_data(disp_data), .o_disp_valid(disp_valid),
        .i_host_valid(hv), .o_host_ready(host_ready), .i_host_addr(haddr), .i_host_data(hdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata),
`ifdef ARB_STATS_EN
        .o_wr_count(wr_count), .o_stall_count(stall_count),
`endif
        .o_fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
    ent_t          q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            e_en, e_we, e_dv, rd1_v, rd2_v;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_dd, rd1_d, rd2_d;
    int            e_wr, e_stall;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Slot-level model: one operation per edge, reads see every write decided before them.
    task automatic model_edge();
        int   sz;
        bit   pop;
        ent_t h;
        sz  = q.size();
        pop = 0;
        if (rst) begin
            q.delete();
            rd1_v = 0; rd2_v = 0; e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0;
            e_dv = 0; e_dd = '0; e_wr = 0; e_stall = 0;
            return;
        end
        if (e_en && e_we && e_wr < 65535) e_wr++;
        e_dv = rd2_v;
        if (rd2_v) e_dd = rd2_d;
        rd2_v = rd1_v; rd2_d = rd1_d; rd1_v = 0;
        if (dreq) begin
            e_en = 1; e_we = 0; e_addr = daddr; rd1_v = 1; rd1_d = ref_mem[daddr];
        end else if (sz != 0 && blank) begin
            h = q.pop_front();
            e_en = 1; e_we = 1; e_addr = h.a; e_wdata = h.d; ref_mem[h.a] = h.d; pop = 1;
        end else begin
            e_en = 0; e_we = 0;
        end
        if (sz != 0 && !pop && e_stall < 65535) e_stall++;
        if (hv && sz < D) begin
            h = {haddr, hdata};
            q.push_back(h);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_we);
        if (e_en) chk("mem_addr", mem_addr, e_addr);
        if (e_en && e_we) chk("mem_wdata", mem_wdata, e_wdata);
        chk("fifo_level", fifo_level, q.size());
        chk("host_ready", host_ready, q.size() < D);
        chk("disp_valid", disp_valid, e_dv);
        if (e_dv) chk("disp_data", disp_data, e_dd);
`ifdef ARB_STATS_EN
        chk("wr_count", wr_count, e_wr);
        chk("stall_count", stall_count, e_stall);
`endif
    endtask

    task automatic idle_inputs();
        blank = 0; dreq = 0; daddr = '0; hv = 0; haddr = '0; hdata = '0;
    endtask

    task automatic do_reset();
        rst = 1; cycle(); cycle(); rst = 0;
    endtask

    typedef struct {
        bit blank; bit dreq; logic [AW-1:0] daddr; bit hv; logic [AW-1:0] haddr; logic [DW-1:0] hdata;
        bit en; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int lvl; bit rdy; bit dv; logic [DW-1:0] dd;
    } vec_t;
    vec_t vt [19];

    initial begin
        // blank dreq daddr hv haddr hdata | en we addr wdata lvl rdy dv dd
        vt[0]  = '{0, 1, 12'h010, 0, 12'h000, 8'h00, 1, 0, 12'h010, 8'h00, 0, 1, 0, 8'h00};
        vt[1]  = '{0, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 1, 0, 8'h00};
        vt[2]  = '{0, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 1, 1, 8'h41};
        vt[3]  = '{0, 0, 12'h000, 1, 12'h020, 8'hA0, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00};
        vt[4]  = '{0, 0, 12'h000, 1, 12'h021, 8'hA1, 0, 0, 12'h000, 8'h00, 2, 1, 0, 8'h00};
        vt[5]  = '{0, 0, 12'h000, 1, 12'h022, 8'hA2, 0, 0, 12'h000, 8'h00, 3, 1, 0, 8'h00};
        vt[6]  = '{0, 0, 12'h000, 1, 12'h023, 8'hA3, 0, 0, 12'h000, 8'h00, 4, 0, 0, 8'h00};
        vt[7]  = '{0, 0, 12'h000, 1, 12'h024, 8'hA4, 0, 0, 12'h000, 8'h00, 4, 0, 0, 8'h00};
        vt[8]  = '{1, 0, 12'h000, 0, 12'h000, 8'h00, 1, 1, 12'h020, 8'hA0, 3, 1, 0, 8'h00};
        vt[9]  = '{1, 0, 12'h000, 0, 12'h000, 8'h00, 1, 1, 12'h021, 8'hA1, 2, 1, 0, 8'h00};
        vt[10] = '{1, 0, 12'h000, 0, 12'h000, 8'h00, 1, 1, 12'h022, 8'hA2, 1, 1, 0, 8'h00};
        vt[11] = '{1, 0, 12'h000, 0, 12'h000, 8'h00, 1, 1, 12'h023, 8'hA3, 0, 1, 0, 8'h00};
        vt[12] = '{1, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 1, 0, 8'h00};
        vt[13] = '{1, 0, 12'h000, 1, 12'h030, 8'h5A, 0, 0, 12'h000, 8'h00, 1, 1, 0, 8'h00};
        vt[14] = '{1, 1, 12'h030, 0, 12'h000, 8'h00, 1, 0, 12'h030, 8'h00, 1, 1, 0, 8'h00};
        vt[15] = '{1, 0, 12'h000, 0, 12'h000, 8'h00, 1, 1, 12'h030, 8'h5A, 0, 1, 0, 8'h00};
        vt[16] = '{1, 1, 12'h030, 0, 12'h000, 8'h00, 1, 0, 12'h030, 8'h00, 0, 1, 1, 8'hA1};
        vt[17] = '{1, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 1, 0, 8'h00};
        vt[18] = '{1, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00, 0, 1, 1, 8'h5A};

        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = DW'(i * 3 + 8'h11);
            ref_mem[i] = DW'(i * 3 + 8'h11);
        end
        mem_rdata = '0;
        idle_inputs();
        do_reset();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_disp_data", disp_data, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_host_ready", host_ready, 1);

        for (int i = 0; i < 19; i++) begin
            blank = vt[i].blank; dreq = vt[i].dreq; daddr = vt[i].daddr;
            hv = vt[i].hv; haddr = vt[i].haddr; hdata = vt[i].hdata;
            cycle();
            chk($sformatf("tbl%0d_en", i), mem_en, vt[i].en);
            chk($sformatf("tbl%0d_we", i), mem_we, vt[i].we);
            if (vt[i].en) chk($sformatf("tbl%0d_addr", i), mem_addr, vt[i].addr);
            if (vt[i].we) chk($sformatf("tbl%0d_wdata", i), mem_wdata, vt[i].wdata);
            chk($sformatf("tbl%0d_level", i), fifo_level, vt[i].lvl);
            chk($sformatf("tbl%0d_ready", i), host_ready, vt[i].rdy);
            chk($sformatf("tbl%0d_dvalid", i), disp_valid, vt[i].dv);
            if (vt[i].dv) chk($sformatf("tbl%0d_ddata", i), disp_data, vt[i].dd);
        end

        // Full FIFO with host holding: one drain, push lands the cycle after the pop.
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            hv = 1; haddr = AW'(12'h040 + i); hdata = DW'(8'hB0 + i); cycle();
        end
        haddr = 12'h044; hdata = 8'hB4; cycle();
        chk("full_ready", host_ready, 0);
        blank = 1; cycle();
        chk("full_pop_addr", mem_addr, 12'h040);
        chk("full_pop_level", fifo_level, 3);
        chk("full_pop_ready", host_ready, 1);
        blank = 0; cycle();
        chk("full_push_level", fifo_level, 4);
        hv = 0; blank = 1;
        for (int i = 1; i < 5; i++) begin
            cycle();
            chk($sformatf("full_drain%0d_addr", i), mem_addr, 12'h040 + i);
            chk($sformatf("full_drain%0d_we", i), mem_we, 1);
        end
        cycle();
        chk("full_ram_b4", ram[12'h044], 8'hB4);
        chk("full_ram_b1", ram[12'h041], 8'hB1);

        // Reset the cycle after a display request, with three writes queued.
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            hv = 1; haddr = AW'(12'h050 + i); hdata = DW'(i); cycle();
        end
        hv = 0; dreq = 1; daddr = 12'h010; cycle();
        chk("rst5_rd_en", mem_en, 1);
        dreq = 0; rst = 1; cycle(); rst = 0;
        chk("rst5_level", fifo_level, 0);
        chk("rst5_mem_en", mem_en, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("rst5_no_dvalid%0d", i), disp_valid, 0);
        end

`ifdef ARB_STATS_EN
        // 3 queued writes held off 10 cycles, then drained.
        idle_inputs();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            hv = 1; haddr = AW'(12'h060 + i); hdata = DW'(8'hC0 + i); cycle();
        end
        hv = 0;
        for (int i = 0; i < 8; i++) cycle();
        blank = 1;
        for (int i = 0; i < 5; i++) cycle();
        chk("stats_wr", wr_count, 3);
        chk("stats_stall", stall_count, 10);
`endif

        // Random traffic on a small address window to force read/write collisions.
        idle_inputs();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit acc;
            if ((n % 200) == 0) blank = $urandom_range(0, 1);
            else if ($urandom_range(0, 15) == 0) blank = ~blank;
            dreq  = ($urandom_range(0, 9) < 4);
            daddr = AW'($urandom_range(0, 15));
            if (!hv) begin
                hv = $urandom_range(0, 1);
                haddr = AW'($urandom_range(0, 15));
                hdata = DW'($urandom);
            end
            acc = hv && (q.size() < D);
            cycle();
            if (acc) hv = 0;
        end
        for (int i = 0; i < 16; i++) chk($sformatf("rand_ram%0d", i), ram[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
